alu_driver: RTL and testbench

ALU_DRIVER -- requirements
Module: alu_driver

---
 rtl/alu_driver.sv | 170 +++++++++++++++++
 tb/tb_alu_driver.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_driver.sv
// alu_driver: issues one command at a time to an external combinational ALU
// through an IDLE -> EXEC -> RESP sequence and keeps a result accumulator.
// Optional statistics outputs (op_count, ovf_count) are built only when the
// macro ALU_DRIVER_STATS_EN is defined.
module alu_driver #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_use_acc,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_f,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_zero,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_y,
  output logic             rsp_zero,
  output logic             rsp_carry,
  output logic             rsp_overflow,
  output logic             rsp_err
`ifdef ALU_DRIVER_STATS_EN
  ,
  output logic [31:0]      op_count,
  output logic [31:0]      ovf_count
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] OP_ILLEGAL = 3'b011;

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] y_r;
  logic             zero_r;
  logic             carry_r;
  logic             ovf_r;
  logic             err_r;
  logic             cmd_ready_r;
  logic             rsp_valid_r;
  logic             accept_s;
  logic             handshake_s;

  // cmd_ready_r is only ever high in IDLE and rsp_valid_r only in RESP, so
  // these qualify the handshakes without decoding the state again.
  assign accept_s    = cmd_valid && cmd_ready_r;
  assign handshake_s = rsp_valid_r && rsp_ready;

  assign cmd_ready    = cmd_ready_r;
  assign alu_a        = a_r;
  assign alu_b        = b_r;
  assign alu_f        = op_r;
  assign rsp_valid    = rsp_valid_r;
  assign rsp_y        = y_r;
  assign rsp_zero     = zero_r;
  assign rsp_carry    = carry_r;
  assign rsp_overflow = ovf_r;
  assign rsp_err      = err_r;

  // Command sequencer: operand capture, result capture, response hold.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      op_r        <= 3'b000;
      acc_r       <= {WIDTH{1'b0}};
      y_r         <= {WIDTH{1'b0}};
      zero_r      <= 1'b0;
      carry_r     <= 1'b0;
      ovf_r       <= 1'b0;
      err_r       <= 1'b0;
      cmd_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            // The accumulator is already updated by the previous EXEC, so
            // back-to-back use_acc commands need no bypass.
            a_r         <= cmd_use_acc ? acc_r : cmd_a;
            b_r         <= cmd_b;
            op_r        <= cmd_op;
            cmd_ready_r <= 1'b0;
            state_r     <= EXEC;
          end else begin
            cmd_ready_r <= 1'b1;
          end
        end
        EXEC: begin
          if (op_r == OP_ILLEGAL) begin
            y_r     <= {WIDTH{1'b0}};
            zero_r  <= 1'b1;
            carry_r <= 1'b0;
            ovf_r   <= 1'b0;
            err_r   <= 1'b1;
          end else begin
            y_r     <= alu_y;
            zero_r  <= alu_zero;
            carry_r <= alu_carry;
            ovf_r   <= alu_overflow;
            err_r   <= 1'b0;
            acc_r   <= alu_y;
          end
          state_r <= RESP;
        end
        RESP: begin
          // rsp_valid rises on the first RESP edge, so a response is
          // presented two edges after the accepting edge.
          if (handshake_s) begin
            rsp_valid_r <= 1'b0;
            cmd_ready_r <= 1'b1;
            state_r     <= IDLE;
          end else begin
            rsp_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          cmd_ready_r <= 1'b0;
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_DRIVER_STATS_EN
  logic [31:0] op_count_r;
  logic [31:0] ovf_count_r;

  assign op_count  = op_count_r;
  assign ovf_count = ovf_count_r;

  // Saturating counters of delivered responses and overflowing responses.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      op_count_r  <= 32'd0;
      ovf_count_r <= 32'd0;
    end else begin
      if (handshake_s && (op_count_r != 32'hFFFF_FFFF)) begin
        op_count_r <= op_count_r + 32'd1;
      end else begin
        op_count_r <= op_count_r;
      end
      if (handshake_s && ovf_r && (ovf_count_r != 32'hFFFF_FFFF)) begin
        ovf_count_r <= ovf_count_r + 32'd1;
      end else begin
        ovf_count_r <= ovf_count_r;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_driver.sv
// Scoreboard bench for alu_driver: a behavioural ALU answers the driver, a
// reference model computes expected responses at issue time, and a monitor
// compares them when the DUT presents a response.
module tb_alu_driver;
  localparam int     W    = 16;
  localparam longint MOD  = 64'd65536;
  localparam longint HALF = 64'd32768;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [W-1:0] cmd_a;
  logic [W-1:0] cmd_b;
  logic         cmd_use_acc;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [2:0]   alu_f;
  logic [W-1:0] alu_y;
  logic         alu_zero;
  logic         alu_carry;
  logic         alu_overflow;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_y;
  logic         rsp_zero;
  logic         rsp_carry;
  logic         rsp_overflow;
  logic         rsp_err;
`ifdef ALU_DRIVER_STATS_EN
  logic [31:0]  op_count;
  logic [31:0]  ovf_count;
`endif

  alu_driver #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
    .alu_y(alu_y), .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
    .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .rsp_overflow(rsp_overflow), .rsp_err(rsp_err)
`ifdef ALU_DRIVER_STATS_EN
    , .op_count(op_count), .ovf_count(ovf_count)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // External ALU: carry is carry-out for ADD and borrow for SUB; the illegal
  // code returns junk so the driver's override is visible.
  logic [W:0] alu_wide;
  always_comb begin
    alu_wide     = '0;
    alu_y        = '0;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    case (alu_f)
      3'b010: begin
        alu_wide     = {1'b0, alu_a} + {1'b0, alu_b};
        alu_y        = alu_wide[W-1:0];
        alu_carry    = alu_wide[W];
        alu_overflow = (alu_a[W-1] == alu_b[W-1]) && (alu_y[W-1] != alu_a[W-1]);
      end
      3'b110: begin
        alu_wide     = {1'b0, alu_a} - {1'b0, alu_b};
        alu_y        = alu_wide[W-1:0];
        alu_carry    = alu_wide[W];
        alu_overflow = (alu_a[W-1] != alu_b[W-1]) && (alu_y[W-1] != alu_a[W-1]);
      end
      3'b000: alu_y = alu_a & alu_b;
      3'b001: alu_y = alu_a | alu_b;
      3'b100: alu_y = alu_a ^ alu_b;
      3'b101: alu_y = ~(alu_a | alu_b);
      3'b111: alu_y = {{(W-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      default: begin
        alu_y        = 16'hDEAD;
        alu_carry    = 1'b1;
        alu_overflow = 1'b1;
      end
    endcase
    alu_zero = (alu_y == '0);
  end

  typedef struct packed {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
    logic         z;
    logic         c;
    logic         v;
    logic         e;
    logic [31:0]  acc_cyc;
  } item_t;

  item_t        sb[$];
  logic [W-1:0] acc_m;
  int           checks = 0;
  int           errors = 0;
  int           hs_cnt = 0;
  int           ovf_cnt = 0;
  int           ready_mode = 0;  // 0: always ready, 1: random, 2: held low

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout/unexpected expected=event (t=%0t)", name, $time);
  endtask

  // Reference model from plain integer arithmetic on the operand values.
  function automatic item_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    item_t  r;
    longint ua, ub, sa, sbv, res;
    ua  = longint'(a);
    ub  = longint'(b);
    sa  = (ua >= HALF) ? ua - MOD : ua;
    sbv = (ub >= HALF) ? ub - MOD : ub;
    r = '0;
    r.op = op;
    r.a  = a;
    r.b  = b;
    case (op)
      3'b010: begin
        res = ua + ub;
        r.y = W'(res % MOD);
        r.c = (res >= MOD);
        r.v = ((sa + sbv) >= HALF) || ((sa + sbv) < -HALF);
      end
      3'b110: begin
        res = ua - ub;
        r.y = W'((res + MOD) % MOD);
        r.c = (ua < ub);
        r.v = ((sa - sbv) >= HALF) || ((sa - sbv) < -HALF);
      end
      3'b000:  r.y = a & b;
      3'b001:  r.y = a | b;
      3'b100:  r.y = a ^ b;
      3'b101:  r.y = ~(a | b);
      3'b111:  r.y = (sa < sbv) ? 16'd1 : 16'd0;
      default: begin r.y = '0; r.e = 1'b1; end
    endcase
    r.z = (r.y == '0);
    return r;
  endfunction

  // Issue one command; noise on cmd_* while the driver is busy must be ignored.
  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic use_acc);
    item_t it;
    int    n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      cmd_valid   = ($urandom_range(0, 3) == 0);
      cmd_op      = 3'($urandom);
      cmd_a       = W'($urandom);
      cmd_b       = W'($urandom);
      cmd_use_acc = 1'($urandom);
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      fail_now("cmd_ready_wait");
      return;
    end
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_a       = a;
    cmd_b       = b;
    cmd_use_acc = use_acc;
    it = model(op, use_acc ? acc_m : a, b);
    @(posedge clk);
    #1;
    cmd_valid  = 1'b0;
    it.acc_cyc = cyc;
    if (!it.e) acc_m = it.y;
    sb.push_back(it);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || rsp_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || rsp_valid) fail_now("drain");
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return W'($urandom);
    endcase
  endfunction

  // Response-side back-pressure.
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = ($urandom_range(0, 2) != 0);
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  // Monitor: operand check in EXEC, latency/value check on arrival, hold
  // check while stalled, cmd_ready check after the handshake.
  logic         in_resp = 1'b0;
  logic         hs_pend = 1'b0;
  logic [W-1:0] snap_y;
  logic [3:0]   snap_f;
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        in_resp = 1'b0;
        hs_pend = 1'b0;
      end else begin
        if (sb.size() > 0 && !in_resp && cyc == sb[0].acc_cyc) begin
          chk("exec_alu_a", alu_a, sb[0].a);
          chk("exec_alu_b", alu_b, sb[0].b);
          chk("exec_alu_f", alu_f, sb[0].op);
        end
        if (rsp_valid) begin
          if (sb.size() == 0) begin
            fail_now("unexpected_rsp");
          end else begin
            if (!in_resp) begin
              chk("rsp_latency", cyc - sb[0].acc_cyc, 2);
              chk("rsp_y", rsp_y, sb[0].y);
              chk("rsp_zero", rsp_zero, sb[0].z);
              chk("rsp_carry", rsp_carry, sb[0].c);
              chk("rsp_overflow", rsp_overflow, sb[0].v);
              chk("rsp_err", rsp_err, sb[0].e);
              snap_y  = rsp_y;
              snap_f  = {rsp_zero, rsp_carry, rsp_overflow, rsp_err};
              in_resp = 1'b1;
            end else begin
              chk("hold_y", rsp_y, snap_y);
              chk("hold_flags", {rsp_zero, rsp_carry, rsp_overflow, rsp_err}, snap_f);
            end
            chk("cmd_ready_in_resp", cmd_ready, 0);
            if (rsp_ready) begin
              hs_cnt++;
              if (sb[0].v) ovf_cnt++;
              void'(sb.pop_front());
              in_resp = 1'b0;
              hs_pend = 1'b1;
            end
          end
        end else begin
          if (hs_pend) chk("cmd_ready_after_rsp", cmd_ready, 1);
          hs_pend = 1'b0;
          if (sb.size() > 0 && cyc == sb[0].acc_cyc + 2) fail_now("rsp_missing");
        end
      end
    end
  end

  task automatic check_stats();
`ifdef ALU_DRIVER_STATS_EN
    chk("op_count", op_count, hs_cnt);
    chk("ovf_count", ovf_count, ovf_cnt);
`endif
  endtask

  initial begin
    int n;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'b000; cmd_a = '0; cmd_b = '0; cmd_use_acc = 1'b0;
    acc_m = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_cmd_ready", cmd_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_y", rsp_y, 0);
    chk("reset_rsp_flags", {rsp_zero, rsp_carry, rsp_overflow, rsp_err}, 0);
    chk("reset_alu_ops", {alu_a, alu_b, alu_f}, 0);
    check_stats();
    reset_n = 1'b1;
    @(negedge clk);
    chk("cmd_ready_after_release", cmd_ready, 1);

    // Directed cases.
    send(3'b010, 16'h7FFF, 16'h0001, 1'b0);
    send(3'b110, 16'h0005, 16'h0005, 1'b0);
    send(3'b110, 16'h1234, 16'h0001, 1'b1);
    send(3'b111, 16'h8000, 16'h0001, 1'b0);
    send(3'b001, 16'h00F0, 16'h0F00, 1'b0);
    send(3'b011, 16'h1234, 16'h5678, 1'b0);
    send(3'b010, 16'hAAAA, 16'h0000, 1'b1);
    send(3'b101, 16'h0F0F, 16'h00FF, 1'b0);
    drain();

    // Stalled response with ignored command pulses.
    ready_mode = 2;
    send(3'b100, 16'hA5A5, 16'h0F0F, 1'b0);
    n = 0;
    while (!rsp_valid && n < 10) begin @(negedge clk); n++; end
    if (!rsp_valid) fail_now("stall_rsp_wait");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cmd_valid = (i % 2 == 0); cmd_op = 3'b010; cmd_a = 16'hFFFF; cmd_b = 16'h0001; cmd_use_acc = 1'b0;
    end
    @(negedge clk);
    cmd_valid  = 1'b0;
    ready_mode = 0;
    drain();

    // Reset while in EXEC aborts the command and clears the accumulator.
    send(3'b010, 16'h1111, 16'h2222, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    sb.delete();
    acc_m = '0; hs_cnt = 0; ovf_cnt = 0;
    @(negedge clk);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    chk("abort_rsp_valid2", rsp_valid, 0);
    reset_n = 1'b1;
    send(3'b010, 16'h4321, 16'h0000, 1'b1);
    send(3'b010, 16'h7FFF, 16'h0001, 1'b0);
    send(3'b000, 16'hF0F0, 16'hFF00, 1'b0);
    drain();
    check_stats();

    // Randomized traffic with random back-pressure.
    ready_mode = 1;
    for (int k = 0; k < 300; k++) begin
      send(3'($urandom_range(0, 7)), pick(), pick(), ($urandom_range(0, 2) == 0));
    end
    drain();
    ready_mode = 0;
    repeat (2) @(negedge clk);
    check_stats();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog actual=running expected=finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
